// File: rtl/gen_leaf_seq.sv
// -----------------------------------------------------------------------------
// gen_leaf_seq
//
// Runs one leaf-generation core through a sequence of consecutive XMSS leaves.
// One leaf job is in flight at a time. The OTS index counts up from first_idx
// and wraps modulo 2^IDX_W. Finished leaves are queued in a small FIFO together
// with their index, and a valid/ready handshake drains them to the consumer.
//
// Parameters
//   KEY_LEN     width of a leaf value
//   IDX_W       leaf index width (1..32)
//   FIFO_DEPTH  output buffer entries (power of two, >= 2)
//
// Ports
//   clk, reset_n    clock, asynchronous active-low reset
//   start           one-cycle run request, honoured only while busy is low
//   first_idx       index of the first leaf of the run
//   leaf_count      number of leaves in the run (zero is a legal empty run)
//   hash_addr       base hash address; only words 0..2 ([255:160]) are kept
//   busy            high from an accepted start until done
//   done            one-cycle pulse when the run has fully drained
//   core_start      one-cycle job launch to the leaf core
//   core_hash_addr  per-leaf address: base words, OTS type, current index
//   core_done       one-cycle completion pulse from the leaf core
//   core_leaf       leaf value, valid together with core_done
//   out_valid       FIFO holds at least one leaf
//   out_ready       consumer takes the head leaf when out_valid is also high
//   out_leaf        head leaf value (zero when the FIFO is empty)
//   out_idx         head leaf index (zero when the FIFO is empty)
//   abort           run cancel, present only with GEN_LEAF_SEQ_ABORT_EN
//
// Build option
//   GEN_LEAF_SEQ_ABORT_EN  adds the abort port and the ABORT state. Without it
//                          a started run always completes.
// -----------------------------------------------------------------------------
module gen_leaf_seq #(
  parameter int KEY_LEN    = 256,
  parameter int IDX_W      = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [IDX_W-1:0]   first_idx,
  input  logic [IDX_W:0]     leaf_count,
  input  logic [255:0]       hash_addr,
  output logic               busy,
  output logic               done,
  output logic               core_start,
  output logic [255:0]       core_hash_addr,
  input  logic               core_done,
  input  logic [KEY_LEN-1:0] core_leaf,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [KEY_LEN-1:0] out_leaf,
  output logic [IDX_W-1:0]   out_idx
`ifdef GEN_LEAF_SEQ_ABORT_EN
  ,
  input  logic               abort
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
`ifdef GEN_LEAF_SEQ_ABORT_EN
    ,
    S_ABORT
`endif
  } state_t;

  state_t state;
  state_t state_next;

  // Run context captured at start
  logic [95:0]        addr_q;
  logic [IDX_W-1:0]   cur_idx;
  logic [IDX_W:0]     remaining;

  // Output FIFO storage and bookkeeping
  logic [KEY_LEN-1:0] leaf_mem [FIFO_DEPTH];
  logic [IDX_W-1:0]   idx_mem  [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      fifo_count;

  // Control strobes produced by the next-state logic
  logic capture;
  logic issue;
  logic push;
  logic pop;
  logic flush;
  logic done_next;

  logic fifo_empty;
  logic fifo_space;

  // The low 160 address bits are replaced per leaf, so they are dropped here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^hash_addr[159:0];

  assign fifo_empty = (fifo_count == '0);
  assign fifo_space = (fifo_count < DEPTH_C);

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // Head values are masked while empty so stale or uninitialised storage
  // never shows on the outputs, including right after an asynchronous reset.
  assign out_leaf = out_valid ? leaf_mem[rd_ptr] : '0;
  assign out_idx  = out_valid ? idx_mem[rd_ptr]  : '0;

  assign core_start = issue;

  // Address layout: base words 0..2, word 3 = OTS type (0), word 4 = index,
  // words 5..7 cleared. Both fields only change on capture or push, so the
  // address holds steady for the whole time a job is outstanding.
  assign core_hash_addr = {addr_q, 32'd0, 32'(cur_idx), 96'd0};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and strobe decode. ISSUE launches a job only when a FIFO slot
  // is free; since a single job is outstanding, that slot is effectively
  // reserved and the later push can never overflow. An abort that coincides
  // with core_done in WAIT finishes the cancel at once instead of waiting for
  // a completion that has already happened.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    issue      = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    done_next  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = (leaf_count == '0) ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef GEN_LEAF_SEQ_ABORT_EN
        if (abort) begin
          flush      = 1'b1;
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else
`endif
        if (fifo_space) begin
          issue      = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
`ifdef GEN_LEAF_SEQ_ABORT_EN
        if (abort && core_done) begin
          flush      = 1'b1;
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else if (abort) begin
          state_next = S_ABORT;
        end else
`endif
        if (core_done) begin
          push       = 1'b1;
          state_next = (remaining == (IDX_W+1)'(1)) ? S_DRAIN : S_ISSUE;
        end
      end
      S_DRAIN: begin
`ifdef GEN_LEAF_SEQ_ABORT_EN
        if (abort) begin
          flush      = 1'b1;
          done_next  = 1'b1;
          state_next = S_IDLE;
        end else
`endif
        if (fifo_empty) begin
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
`ifdef GEN_LEAF_SEQ_ABORT_EN
      S_ABORT: begin
        if (core_done) begin
          flush      = 1'b1;
          done_next  = 1'b1;
          state_next = S_IDLE;
        end
      end
`endif
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Run context, busy and done. done is registered so it lands one cycle
  // after the drain condition is seen, and busy drops in that same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= '0;
      cur_idx   <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= done_next;
      if (capture) begin
        addr_q    <= hash_addr[255:160];
        cur_idx   <= first_idx;
        remaining <= leaf_count;
        busy      <= 1'b1;
      end else if (done_next) begin
        busy <= 1'b0;
      end
      if (push) begin
        cur_idx   <= cur_idx + IDX_W'(1);
        remaining <= remaining - (IDX_W+1)'(1);
      end
    end
  end

  // FIFO pointers and occupancy. A push and a pop in the same cycle cancel
  // out in the count. A flush wins over a concurrent pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage needs no reset: entries are only visible through the
  // occupancy-masked head outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      leaf_mem[wr_ptr] <= core_leaf;
      idx_mem[wr_ptr]  <= cur_idx;
    end
  end

endmodule

// File: tb/tb_gen_leaf_seq.sv
// -----------------------------------------------------------------------------
// tb_gen_leaf_seq
//
// Directed bench for gen_leaf_seq with default parameters (KEY_LEN=256,
// IDX_W=10, FIFO_DEPTH=4). A small leaf-core stand-in answers each
// core_start with leaf = idx * 0x11. Inputs change one time unit after the
// rising edge and outputs are observed at that same point.
// With GEN_LEAF_SEQ_ABORT_EN defined the abort scenario is also run.
// -----------------------------------------------------------------------------
module tb_gen_leaf_seq;

  localparam int KEY_LEN = 256;
  localparam int IDX_W   = 10;
  localparam int DEPTH   = 4;
  localparam logic [255:0] HASH = {96'h0123_4567_89AB_CDEF_0246_8ACE, {160{1'b1}}};

  logic               clk;
  logic               reset_n;
  logic               start;
  logic [IDX_W-1:0]   first_idx;
  logic [IDX_W:0]     leaf_count;
  logic [255:0]       hash_addr;
  logic               busy;
  logic               done;
  logic               core_start;
  logic [255:0]       core_hash_addr;
  logic               core_done;
  logic [KEY_LEN-1:0] core_leaf;
  logic               out_valid;
  logic               out_ready;
  logic [KEY_LEN-1:0] out_leaf;
  logic [IDX_W-1:0]   out_idx;
`ifdef GEN_LEAF_SEQ_ABORT_EN
  logic               abort;
`endif

  int errors   = 0;
  int checks   = 0;
  int n_starts = 0;
  int base_starts;
  bit seen;

  gen_leaf_seq #(
    .KEY_LEN(KEY_LEN),
    .IDX_W(IDX_W),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .first_idx(first_idx),
    .leaf_count(leaf_count),
    .hash_addr(hash_addr),
    .busy(busy),
    .done(done),
    .core_start(core_start),
    .core_hash_addr(core_hash_addr),
    .core_done(core_done),
    .core_leaf(core_leaf),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_leaf(out_leaf),
    .out_idx(out_idx)
`ifdef GEN_LEAF_SEQ_ABORT_EN
    ,
    .abort(abort)
`endif
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts launched jobs so runs can be checked for the exact number issued.
  always @(posedge clk) begin
    if (core_start === 1'b1) n_starts <= n_starts + 1;
  end

  // Global time limit in case a bounded wait is ever bypassed.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: time limit reached before summary");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [255:0] leaf_of(input int idx);
    logic [255:0] v;
    v = 256'(idx);
    return v * 256'h11;
  endfunction

  function automatic logic [255:0] exp_addr(input int idx);
    logic [255:0] a;
    a = HASH;
    a[159:0]  = '0;
    a[127:96] = 32'(idx);
    return a;
  endfunction

  task automatic check_output(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int first, input int count);
    first_idx  = IDX_W'(first);
    leaf_count = (IDX_W+1)'(count);
    hash_addr  = HASH;
    start      = 1'b1;
    cycle();
    start      = 1'b0;
  endtask

  task automatic wait_core_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (core_start === 1'b1) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
  endtask

  // Core stand-in: waits for a launch, checks the address, then answers.
  task automatic serve(input int idx);
    bit found;
    wait_core_start(found);
    check_output("core_start_seen", 256'(found), 256'd1);
    check_output("core_hash_addr", core_hash_addr, exp_addr(idx));
    cycle();
    check_output("core_hash_addr_hold", core_hash_addr, exp_addr(idx));
    core_done = 1'b1;
    core_leaf = leaf_of(idx);
    cycle();
    core_done = 1'b0;
  endtask

  task automatic pop_check(input int idx);
    check_output("out_valid_head", 256'(out_valid), 256'd1);
    check_output("out_idx", 256'(out_idx), 256'(idx));
    check_output("out_leaf", out_leaf, leaf_of(idx));
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic wait_done();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    check_output("done_seen", 256'(found), 256'd1);
    check_output("busy_after_done", 256'(busy), 256'd0);
    cycle();
    check_output("done_single_pulse", 256'(done), 256'd0);
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    first_idx  = '0;
    leaf_count = '0;
    hash_addr  = '0;
    core_done  = 1'b0;
    core_leaf  = '0;
    out_ready  = 1'b0;
`ifdef GEN_LEAF_SEQ_ABORT_EN
    abort      = 1'b0;
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_busy", 256'(busy), 256'd0);
    check_output("rst_done", 256'(done), 256'd0);
    check_output("rst_core_start", 256'(core_start), 256'd0);
    check_output("rst_core_hash_addr", core_hash_addr, 256'd0);
    check_output("rst_out_valid", 256'(out_valid), 256'd0);
    check_output("rst_out_leaf", out_leaf, 256'd0);
    check_output("rst_out_idx", 256'(out_idx), 256'd0);
    reset_n = 1'b1;
    cycle();

    // Basic run: indices 5, 6, 7 queued, then drained in order
    $display("[TB] basic run");
    apply_stimulus(5, 3);
    check_output("basic_core_start_latency", 256'(core_start), 256'd1);
    check_output("basic_busy", 256'(busy), 256'd1);
    serve(5);
    serve(6);
    serve(7);
    pop_check(5);
    pop_check(6);
    pop_check(7);
    check_output("basic_empty", 256'(out_valid), 256'd0);
    check_output("basic_done_not_yet", 256'(done), 256'd0);
    cycle();
    check_output("basic_done", 256'(done), 256'd1);
    check_output("basic_busy_clear", 256'(busy), 256'd0);
    cycle();
    check_output("basic_done_pulse", 256'(done), 256'd0);

    // Backpressure: 4 jobs fill the FIFO, then issue stalls
    $display("[TB] backpressure");
    base_starts = n_starts;
    apply_stimulus(20, 6);
    serve(20);
    serve(21);
    serve(22);
    serve(23);
    for (int i = 0; i < 6; i++) begin
      // Stray completion while stalled in ISSUE must not be queued
      core_done = (i == 2);
      core_leaf = 256'hDEAD;
      cycle();
    end
    core_done = 1'b0;
    check_output("bp_stall_starts", 256'(n_starts - base_starts), 256'd4);
    check_output("bp_stall_no_start", 256'(core_start), 256'd0);
    pop_check(20);
    serve(24);
    pop_check(21);
    serve(25);
    pop_check(22);
    pop_check(23);
    pop_check(24);
    pop_check(25);
    check_output("bp_empty", 256'(out_valid), 256'd0);
    wait_done();
    check_output("bp_total_starts", 256'(n_starts - base_starts), 256'd6);

    // Index wrap: 1023 then 0
    $display("[TB] index wrap");
    apply_stimulus(1023, 2);
    serve(1023);
    serve(0);
    pop_check(1023);
    pop_check(0);
    wait_done();

    // Empty run: done two cycles after start, no job launched
    $display("[TB] zero count");
    base_starts = n_starts;
    apply_stimulus(3, 0);
    check_output("zero_busy", 256'(busy), 256'd1);
    check_output("zero_done_early", 256'(done), 256'd0);
    cycle();
    check_output("zero_done", 256'(done), 256'd1);
    check_output("zero_busy_clear", 256'(busy), 256'd0);
    cycle();
    check_output("zero_done_pulse", 256'(done), 256'd0);
    check_output("zero_no_start", 256'(n_starts - base_starts), 256'd0);

    // Ignored start while busy, then push and pop in the same cycle at 3 entries
    $display("[TB] simultaneous events");
    apply_stimulus(40, 4);
    wait_core_start(seen);
    check_output("sim_core_start_seen", 256'(seen), 256'd1);
    cycle();
    first_idx  = IDX_W'(100);
    leaf_count = (IDX_W+1)'(1);
    start      = 1'b1;
    cycle();
    start      = 1'b0;
    check_output("sim_busy_held", 256'(busy), 256'd1);
    check_output("sim_addr_unchanged", core_hash_addr, exp_addr(40));
    core_done = 1'b1;
    core_leaf = leaf_of(40);
    cycle();
    core_done = 1'b0;
    serve(41);
    serve(42);
    wait_core_start(seen);
    check_output("sim_last_addr", core_hash_addr, exp_addr(43));
    cycle();
    core_done = 1'b1;
    core_leaf = leaf_of(43);
    out_ready = 1'b1;
    cycle();
    core_done = 1'b0;
    out_ready = 1'b0;
    pop_check(41);
    pop_check(42);
    pop_check(43);
    check_output("sim_count_was_3", 256'(out_valid), 256'd0);
    wait_done();

    // Asynchronous reset in the middle of a WAIT
    $display("[TB] async reset");
    apply_stimulus(7, 3);
    serve(7);
    wait_core_start(seen);
    cycle();
    check_output("ar_pre_valid", 256'(out_valid), 256'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("ar_busy", 256'(busy), 256'd0);
    check_output("ar_out_valid", 256'(out_valid), 256'd0);
    check_output("ar_core_hash_addr", core_hash_addr, 256'd0);
    check_output("ar_out_leaf", out_leaf, 256'd0);
    cycle();
    reset_n   = 1'b1;
    core_done = 1'b1;
    core_leaf = leaf_of(8);
    cycle();
    core_done = 1'b0;
    check_output("ar_late_done_ignored", 256'(out_valid), 256'd0);
    cycle();
    check_output("ar_still_idle", 256'(busy), 256'd0);
    apply_stimulus(9, 1);
    serve(9);
    pop_check(9);
    wait_done();

`ifdef GEN_LEAF_SEQ_ABORT_EN
    // Abort while a job is outstanding with 2 leaves queued
    $display("[TB] abort");
    base_starts = n_starts;
    apply_stimulus(60, 5);
    serve(60);
    serve(61);
    wait_core_start(seen);
    cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    repeat (3) cycle();
    check_output("ab_no_new_start", 256'(n_starts - base_starts), 256'd3);
    check_output("ab_done_waits", 256'(done), 256'd0);
    core_done = 1'b1;
    core_leaf = leaf_of(62);
    cycle();
    core_done = 1'b0;
    check_output("ab_done", 256'(done), 256'd1);
    check_output("ab_flushed", 256'(out_valid), 256'd0);
    check_output("ab_busy_clear", 256'(busy), 256'd0);
    cycle();
    check_output("ab_done_pulse", 256'(done), 256'd0);
    check_output("ab_total_starts", 256'(n_starts - base_starts), 256'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
